bus_arbiter: RTL and testbench

Two-master, single-slave arbiter sharing the CPU's one data-memory port between the load/store unit (master 0) and a second requester such as a debug/DMA loader fed from the USB CDC FIFO (master 1). It sits between the requesters and `mem_control`/MMIO decode. It serialises accesses with round-robin fairness, allows one outstanding transaction, and bounds slave latency with a timeout that returns an error response.

---
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master / single-slave arbiter for the shared data-memory port.
//   Master 0 (load/store unit) and master 1 (debug/DMA loader) compete; round-robin
//   on ties, one outstanding transaction, optional response timeout.
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   mN_req_i/we_i/addr_i/      master N request and payload (held until mN_gnt_o)
//   wdata_i/be_i
//   mN_gnt_o                   one-cycle accept pulse (combinational with s_gnt_i)
//   mN_rvalid_o                one-cycle response pulse
//   mN_rdata_o, mN_err_o       response data / timeout flag, held until next response
//   s_req_o, s_we_o, s_addr_o, slave request and latched payload
//   s_wdata_o, s_be_o
//   s_gnt_i, s_rvalid_i,       slave accept, response valid and read data
//   s_rdata_i
module bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_be_o,
  input  logic                s_gnt_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  // Keep at least one counter bit so TIMEOUT=0 (disabled) still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;    // 1 = master 1 won the previous arbitration
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                err0_q, err0_d, err1_q, err1_d;

  logic                win1;
  logic                timeout_hit;

  // Master 1 wins when alone, or on a tie when master 0 won last time.
  assign win1        = m1_req_i & (~m0_req_i | ~last_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d = REQ;
          owner_d = win1;
          last_d  = win1;
          we_d    = win1 ? m1_we_i    : m0_we_i;
          addr_d  = win1 ? m1_addr_i  : m0_addr_i;
          wdata_d = win1 ? m1_wdata_i : m0_wdata_i;
          be_d    = win1 ? m1_be_i    : m0_be_i;
        end
      end
      REQ: begin
        if (s_gnt_i) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        // A real response in the timeout cycle takes priority over the error.
        if (s_rvalid_i || timeout_hit) begin
          state_d           = IDLE;
          rvalid_d[owner_q] = 1'b1;
          if (owner_q) begin
            rdata1_d = s_rvalid_i ? s_rdata_i : '0;
            err1_d   = ~s_rvalid_i;
          end else begin
            rdata0_d = s_rvalid_i ? s_rdata_i : '0;
            err0_d   = ~s_rvalid_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign s_req_o     = (state_q == REQ);
  assign m0_gnt_o    = s_req_o & s_gnt_i & ~owner_q;
  assign m1_gnt_o    = s_req_o & s_gnt_i &  owner_q;
  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_be_o      = be_q;
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign m0_err_o    = err0_q;
  assign m1_err_o    = err1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;

  logic          clk_i  = 1'b0;
  logic          rstn_i = 1'b0;
  logic          mreq [2];
  logic          mwe  [2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd  [2];
  logic [BW-1:0] mbe  [2];
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic [BW-1:0] s_be_o;
  logic          s_gnt_i = 1'b0, s_rvalid_i = 1'b0;
  logic [DW-1:0] s_rdata_i = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_req_i(mreq[0]), .m0_we_i(mwe[0]), .m0_addr_i(maddr[0]), .m0_wdata_i(mwd[0]), .m0_be_i(mbe[0]),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(mreq[1]), .m1_we_i(mwe[1]), .m1_addr_i(maddr[1]), .m1_wdata_i(mwd[1]), .m1_be_i(mbe[1]),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            active, accepted;
  int            owner, waited, last_win, mw;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;
  logic [BW-1:0] p_be;
  logic [1:0]    exp_rv, exp_er;
  logic [DW-1:0] exp_rd[2];
  bit            gnt_seen[2];

  task automatic respond(input logic [DW-1:0] d, input logic e);
    exp_rv[owner] = 1'b1;
    exp_rd[owner] = d;
    exp_er[owner] = e;
    active        = 0;
  endtask

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      active = 0; accepted = 0; owner = 0; waited = 0; last_win = 1;
      p_we = 0; p_addr = '0; p_wd = '0; p_be = '0;
      exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    end else begin
      exp_rv = '0;
      if (!active) begin
        if (mreq[0] || mreq[1]) begin
          if (mreq[0] && mreq[1]) mw = 1 - last_win;
          else mw = mreq[1] ? 1 : 0;
          last_win = mw; owner = mw; active = 1; accepted = 0;
          p_we = mwe[mw]; p_addr = maddr[mw]; p_wd = mwd[mw]; p_be = mbe[mw];
        end
      end else if (!accepted) begin
        if (s_gnt_i) begin accepted = 1; waited = 0; end
      end else begin
        if (s_rvalid_i) respond(s_rdata_i, 1'b0);
        else if (TO != 0 && waited == TO) respond('0, 1'b1);
        else waited++;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk_i) begin
    logic esreq, eg0, eg1;
    esreq = active && !accepted;
    eg0   = esreq && s_gnt_i && owner == 0;
    eg1   = esreq && s_gnt_i && owner == 1;
    gnt_seen[0] = eg0;
    gnt_seen[1] = eg1;
    chk("s_req", s_req_o, esreq);
    chk("m0_gnt", m0_gnt_o, eg0);
    chk("m1_gnt", m1_gnt_o, eg1);
    chk("s_we", s_we_o, p_we);
    chk("s_addr", s_addr_o, p_addr);
    chk("s_wdata", s_wdata_o, p_wd);
    chk("s_be", s_be_o, p_be);
    chk("m0_rvalid", m0_rvalid_o, exp_rv[0]);
    chk("m1_rvalid", m1_rvalid_o, exp_rv[1]);
    chk("m0_rdata", m0_rdata_o, exp_rd[0]);
    chk("m1_rdata", m1_rdata_o, exp_rd[1]);
    chk("m0_err", m0_err_o, exp_er[0]);
    chk("m1_err", m1_err_o, exp_er[1]);
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk_i); #1; endtask
  task automatic smp();  @(negedge clk_i);     endtask

  task automatic set_m(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    mreq[i] = r; mwe[i] = w; maddr[i] = a; mwd[i] = d; mbe[i] = b;
  endtask

  task automatic do_reset();
    step();
    rstn_i = 1'b0;
    set_m(0, 0, 0, '0, '0, '0); set_m(1, 0, 0, '0, '0, '0);
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
    smp();
    chk("rst_sreq", s_req_o, 0);
    chk("rst_m0_rvalid", m0_rvalid_o, 0);
    chk("rst_m1_err", m1_err_o, 0);
    step();
    step();
    rstn_i = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sreq_n, g_n;
    int order[$];
    set_m(0, 0, 0, '0, '0, '0); set_m(1, 0, 0, '0, '0, '0);

    // Single m0 read, zero wait states.
    do_reset();
    step(); set_m(0, 1, 0, 32'h100, '0, 4'hF);
    smp();  chk("t1_c0_sreq", s_req_o, 0);
    step(); s_gnt_i = 1;
    smp();  chk("t1_c1_gnt", m0_gnt_o, 1); chk("t1_c1_addr", s_addr_o, 32'h100);
    step(); mreq[0] = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
    smp();  chk("t1_c2_rvalid", m0_rvalid_o, 0);
    step(); s_rvalid_i = 0;
    smp();
    chk("t1_c3_rvalid", m0_rvalid_o, 1);
    chk("t1_c3_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("t1_c3_err", m0_err_o, 0);
    chk("t1_c3_m1_rvalid", m1_rvalid_o, 0);
    chk("t1_model_rdata", exp_rd[0], 32'hDEADBEEF);

    // Ties after reset: m0, m1, m0, m1.
    do_reset();
    step();
    set_m(0, 1, 0, 32'h10, '0, 4'hF); set_m(1, 1, 1, 32'h20, 32'h55, 4'h1);
    s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'h77;
    for (int c = 0; c < 14; c++) begin
      smp();
      if (m0_gnt_o) order.push_back(0);
      if (m1_gnt_o) order.push_back(1);
      chk("tie_overlap", m0_gnt_o & m1_gnt_o, 0);
      step();
    end
    chk("tie_count_ge4", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      chk("tie_0", order[0], 0); chk("tie_1", order[1], 1);
      chk("tie_2", order[2], 0); chk("tie_3", order[3], 1);
    end
    mreq[0] = 0; mreq[1] = 0;
    step(); step(); s_gnt_i = 0; s_rvalid_i = 0;
    step();

    // m1 write, slave grant delayed three cycles.
    set_m(1, 1, 1, 32'h200, 32'h1234, 4'b0011);
    smp();
    sreq_n = 0; g_n = 0;
    for (int k = 0; k < 4; k++) begin
      step(); s_gnt_i = (k == 3);
      smp(); sreq_n += int'(s_req_o); g_n += int'(m1_gnt_o);
    end
    step(); mreq[1] = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hA5A50000;
    smp();  sreq_n += int'(s_req_o);
    step(); s_rvalid_i = 0;
    smp();
    chk("wr_sreq_cycles", sreq_n, 4);
    chk("wr_gnt_pulses", g_n, 1);
    chk("wr_rvalid", m1_rvalid_o, 1);
    chk("wr_err", m1_err_o, 0);
    chk("wr_be", s_be_o, 4'b0011);

    // Timeout: slave never responds.
    step(); set_m(0, 1, 0, 32'h300, '0, 4'hF);
    step(); s_gnt_i = 1;
    step(); mreq[0] = 0; s_gnt_i = 0;
    n = 0;
    smp();
    while (!m0_rvalid_o && n < 20) begin step(); n++; smp(); end
    chk("to_latency", n, TO + 1);
    chk("to_err", m0_err_o, 1);
    chk("to_rdata", m0_rdata_o, 0);
    chk("to_model_err", exp_er[0], 1);
    step(); s_rvalid_i = 1; s_rdata_i = 32'hBAD;
    smp();  chk("to_idle_sreq", s_req_o, 0);
    step(); s_rvalid_i = 0;
    smp();  chk("to_late_rvalid", m0_rvalid_o, 0); chk("to_err_held", m0_err_o, 1);

    // Reset during RESP.
    step(); set_m(0, 1, 0, 32'h400, '0, 4'hF);
    step(); s_gnt_i = 1;
    step(); mreq[0] = 0; s_gnt_i = 0;
    step(); rstn_i = 0;
    smp();
    chk("rr_err", m0_err_o, 0); chk("rr_addr", s_addr_o, 0); chk("rr_sreq", s_req_o, 0);
    step(); step(); rstn_i = 1; s_rvalid_i = 1;
    smp();  chk("rr_no_rvalid0", m0_rvalid_o, 0);
    step(); s_rvalid_i = 0;
    smp();  chk("rr_no_rvalid1", m0_rvalid_o, 0);
    step(); set_m(0, 1, 0, 32'h500, '0, 4'hF); set_m(1, 1, 0, 32'h600, '0, 4'hF); s_gnt_i = 1;
    step();
    smp();  chk("rr_tie_m0", m0_gnt_o, 1); chk("rr_tie_m1", m1_gnt_o, 0);
    step(); mreq[0] = 0; mreq[1] = 0; s_gnt_i = 0; s_rvalid_i = 1;
    step(); s_gnt_i = 1;
    step(); s_gnt_i = 0;
    step(); s_rvalid_i = 0;
    step();

    // Spurious slave signals while idle.
    s_gnt_i = 1; s_rvalid_i = 1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("sp_sreq", s_req_o, 0);
      chk("sp_gnt", m0_gnt_o | m1_gnt_o, 0);
      chk("sp_rvalid", m0_rvalid_o | m1_rvalid_o, 0);
      step();
    end
    s_gnt_i = 0; s_rvalid_i = 0;

    // Randomized traffic, checked by the every-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      step();
      rstn_i = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 2; i++) begin
        if (mreq[i] && gnt_seen[i]) begin
          mreq[i] = $urandom_range(0, 1);
          if (mreq[i]) set_m(i, 1, $urandom_range(0, 1), $urandom, $urandom, BW'($urandom));
        end else if (!mreq[i] && $urandom_range(0, 2) == 0) begin
          set_m(i, 1, $urandom_range(0, 1), $urandom, $urandom, BW'($urandom));
        end
      end
      s_gnt_i    = $urandom_range(0, 1);
      s_rvalid_i = ($urandom_range(0, 9) < 3);
      s_rdata_i  = $urandom;
    end
    step(); rstn_i = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
